// File: rtl/nibble_adder_seq.sv
// ----------------------------------------------------------------------------
// nibble_adder_seq
//
// Multi-cycle WIDTH-bit adder/subtractor. One 4-bit ripple-carry slice is
// reused over four successive cycles, least significant nibble first. The
// sequencer handshake is start/busy/done; results are registered and held
// until the next completion.
//
// Configuration macro:
//   NIBBLE_ADDER_SUB_EN  defined   -> sub=1 computes a-b (B inverted, cin=1)
//                        undefined -> sub is ignored, every op is a+b, cin=0
//
// Parameters:
//   WIDTH   operand/result width, 13..16 (always exactly four nibble steps)
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request an operation (sampled only while busy=0)
//   sub     in   1: a-b, 0: a+b (sampled with start)
//   a, b    in   operands (sampled with start)
//   busy    out  operation in progress
//   done    out  one-cycle pulse when q/cout/zero update
//   q       out  result, modulo 2^WIDTH
//   cout    out  carry out of bit WIDTH-1 (subtraction: 1 = no borrow)
//   zero    out  q == 0
// ----------------------------------------------------------------------------

// 4-bit ripple-carry slice. Exposes the carry out of every bit so the
// caller can pick the carry out of a bit below the top of the nibble.
module nibble_slice (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic [3:0] co_o
);
    always_comb begin
        logic c;
        c    = c_i;
        s_o  = '0;
        co_o = '0;
        for (int i = 0; i < 4; i++) begin
            s_o[i]  = a_i[i] ^ b_i[i] ^ c;
            c       = (a_i[i] & b_i[i]) | (a_i[i] & c) | (b_i[i] & c);
            co_o[i] = c;
        end
    end
endmodule

module nibble_adder_seq #(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic             cout,
    output logic             zero
);
    // Bit position, within the top nibble, of operand bit WIDTH-1. Its
    // carry out is the true carry of the WIDTH-bit operation; anything the
    // slice produces above it comes from the zero-filled padding.
    localparam int TOPB = WIDTH - 13;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  step_q;
    logic [15:0] a_w_q;     // working operand A, zero-padded to 16 bits
    logic [15:0] b_w_q;     // working operand B (possibly inverted), padded
    logic        carry_q;   // carry into the current nibble
    logic [15:0] acc_q;     // sum nibbles collected so far
    logic [WIDTH-1:0] q_q;
    logic        cout_q;
    logic        zero_q;
    logic        done_q;

    // ------------------------------------------------------------------
    // Operand capture. Padding above WIDTH is zero on both operands, so
    // B is inverted at its own width before being extended.
    // ------------------------------------------------------------------
    logic [15:0] a_load;
    logic [15:0] b_load;
    logic        cin_load;

    assign a_load = 16'(a);

`ifdef NIBBLE_ADDER_SUB_EN
    // Two's complement subtraction: a + ~b + 1.
    assign b_load   = sub ? 16'(~b) : 16'(b);
    assign cin_load = sub;
`else
    // Subtraction not built: sub is accepted on the port and dropped.
    logic unused_sub;
    assign unused_sub = sub;
    assign b_load     = 16'(b);
    assign cin_load   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Shared slice, fed the nibble pair selected by the step counter.
    // ------------------------------------------------------------------
    logic [3:0] nib_a;
    logic [3:0] nib_b;
    logic [3:0] slice_s;
    logic [3:0] slice_co;
    logic       last_step;

    assign nib_a     = a_w_q[{step_q, 2'b00} +: 4];
    assign nib_b     = b_w_q[{step_q, 2'b00} +: 4];
    assign last_step = (step_q == 2'd3);

    nibble_slice u_slice (
        .a_i  (nib_a),
        .b_i  (nib_b),
        .c_i  (carry_q),
        .s_o  (slice_s),
        .co_o (slice_co)
    );

    // Intermediate per-bit carries are only needed at bit TOPB and bit 3.
    logic unused_co;
    assign unused_co = ^slice_co;

    // Accumulator including the nibble being produced this cycle; on the
    // last step this is the complete result.
    logic [15:0] acc_d;
    always_comb begin
        acc_d = acc_q;
        acc_d[{step_q, 2'b00} +: 4] = slice_s;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start)     state_d = RUN;
            RUN:  if (last_step) state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (all driven straight from registers)
    // ------------------------------------------------------------------
    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        q    = q_q;
        cout = cout_q;
        zero = zero_q;
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q  <= '0;
            a_w_q   <= '0;
            b_w_q   <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            q_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // done is a single-cycle pulse, re-armed only by a completion.
            done_q <= (state_q == RUN) && last_step;

            unique case (state_q)
                IDLE: begin
                    // start is only looked at here, so a start during RUN
                    // neither queues nor resamples the operands.
                    if (start) begin
                        a_w_q   <= a_load;
                        b_w_q   <= b_load;
                        carry_q <= cin_load;
                        step_q  <= 2'd0;
                        acc_q   <= '0;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_co[3];
                    step_q  <= step_q + 2'd1;
                    if (last_step) begin
                        q_q    <= acc_d[WIDTH-1:0];
                        cout_q <= slice_co[TOPB];
                        zero_q <= (acc_d[WIDTH-1:0] == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_adder_seq.sv
module tb_nibble_adder_seq;
    localparam int W = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic         cout;
    logic         zero;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Expected value of q currently held (from the model, never from DUT).
    logic [W-1:0] held_q = '0;

    always #5 clk = ~clk;

    nibble_adder_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .cout  (cout),
        .zero  (zero)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain modular arithmetic on the operand values.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms,
                         output logic [W-1:0] mq, output logic mc);
        int lim;
        int r;
        bit do_sub;
        lim = 1 << W;
`ifdef NIBBLE_ADDER_SUB_EN
        do_sub = ms;
`else
        do_sub = 1'b0;
`endif
        if (do_sub) begin
            r  = int'(ma) - int'(mb);
            if (r < 0) r += lim;
            mc = (ma >= mb);
        end else begin
            r  = int'(ma) + int'(mb);
            mc = (r >= lim);
            r  = r % lim;
        end
        mq = W'(r);
    endtask

    // Called just after a falling edge. Leaves off in the done cycle, so a
    // following call issues its start back-to-back with the completion.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic ts,
                          input string tag);
        logic [W-1:0] eq;
        logic         ec;
        model(ta, tb_, ts, eq, ec);
        a = ta; b = tb_; sub = ts; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom);
        chk({tag, ".busy0"}, busy, 1);
        chk({tag, ".done0"}, done, 0);
        for (int i = 1; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            chk({tag, ".busy"}, busy, 1);
            chk({tag, ".done"}, done, 0);
            chk({tag, ".qheld"}, q, held_q);
        end
        @(posedge clk); @(negedge clk);
        chk({tag, ".done_end"}, done, 1);
        chk({tag, ".busy_end"}, busy, 0);
        chk({tag, ".q"}, q, eq);
        chk({tag, ".cout"}, cout, ec);
        chk({tag, ".zero"}, zero, (eq == '0));
        held_q = eq;
    endtask

    initial begin
        logic [W-1:0] eq;
        logic         ec;

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.q",    q,    0);
        chk("rst.cout", cout, 0);
        chk("rst.zero", zero, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(15'h1234, 15'h0FFF, 1'b0, "add");
        @(negedge clk);
        chk("add.done_pulse", done, 0);
        run_op(15'h7FFF, 15'h0001, 1'b0, "wrap");
        run_op(15'h0005, 15'h0003, 1'b1, "sub53");
        run_op(15'h0003, 15'h0005, 1'b1, "sub35");
        run_op(15'h7FFF, 15'h7FFF, 1'b0, "maxadd");
        run_op(15'h0000, 15'h0000, 1'b1, "sub00");
        @(negedge clk);

        // Busy collision: second start at k+2 is dropped.
        model(15'h0101, 15'h0202, 1'b0, eq, ec);
        a = 15'h0101; b = 15'h0202; sub = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk);           // edge k
        start = 1'b0;
        @(posedge clk); @(negedge clk);           // edge k+1
        a = 15'h4444; b = 15'h1111; sub = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk);           // edge k+2
        start = 1'b0;
        chk("coll.busy", busy, 1);
        @(posedge clk); @(negedge clk);           // edge k+3
        chk("coll.done_early", done, 0);
        @(posedge clk); @(negedge clk);           // edge k+4
        chk("coll.done", done, 1);
        chk("coll.q", q, eq);
        chk("coll.cout", cout, ec);
        held_q = eq;
        // start in the done cycle is accepted
        run_op(15'h4444, 15'h1111, 1'b0, "coll2");
        @(negedge clk);

        // Async reset in the middle of an operation
        a = 15'h2222; b = 15'h1111; sub = 1'b0; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        @(posedge clk); @(posedge clk);           // edges k+1, k+2
        #2 rst_n = 1'b0;
        #1;
        chk("mrst.busy", busy, 0);
        chk("mrst.done", done, 0);
        chk("mrst.q",    q,    0);
        chk("mrst.cout", cout, 0);
        chk("mrst.zero", zero, 0);
        held_q = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mrst.nodone", done, 0);
            chk("mrst.idle", busy, 0);
        end
        run_op(15'h0ABC, 15'h0123, 1'b0, "post_rst");

        // Randomized, back-to-back
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rnd%0d", i));
        end
        @(negedge clk);
        chk("end.done", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
